// File: rtl/cache_fill_ctrl.sv
// L1 miss controller: optional dirty-victim eviction, then a block fill from main memory.
// Miss/victim addresses are latched on the miss cycle so the pipeline may move on.
module cache_fill_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int WORDS     = 8,
  parameter int BYTE_OFF  = 1,
  parameter int WRITEBACK = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_miss_detected,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_victim_dirty,
  input  logic [ADDR_W-1:0] i_victim_addr,
  input  logic              i_wrt,
  input  logic              i_pause,
  input  logic              i_mem_data_vld,
  output logic              o_mem_rd_req,
  output logic              o_mem_wr_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_cache_addr,
  output logic              o_cache_rd,
  output logic              o_write_data_array,
  output logic              o_write_tag_array,
  output logic              o_fsm_busy
);
  localparam int WB    = $clog2(WORDS);
  localparam int OFF_W = WB + BYTE_OFF;
  localparam int CW    = WB + 1;

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_miss_addr, r_victim_addr;
  logic [CW-1:0]     r_evict_cnt, r_req_cnt, r_ret_cnt;
  logic [CW-1:0]     w_evict_cnt_nxt, w_req_cnt_nxt, w_ret_cnt_nxt;
  logic              w_latch, w_miss;

  // Block-aligned base with the word index dropped in above the byte offset.
  function automatic logic [ADDR_W-1:0] f_word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [WB-1:0]     idx);
    logic [ADDR_W-1:0] hi_mask;
    hi_mask = {ADDR_W{1'b1}} << OFF_W;
    return (base & hi_mask) | (ADDR_W'(idx) << BYTE_OFF);
  endfunction

  // The async reset forces IDLE, but a live miss must not raise busy while reset is held.
  assign w_miss = i_miss_detected & i_rst_n;

  always_comb begin
    w_state_nxt        = r_state;
    w_evict_cnt_nxt    = r_evict_cnt;
    w_req_cnt_nxt      = r_req_cnt;
    w_ret_cnt_nxt      = r_ret_cnt;
    w_latch            = 1'b0;
    o_mem_rd_req       = 1'b0;
    o_mem_wr_req       = 1'b0;
    o_cache_rd         = 1'b0;
    o_write_data_array = 1'b0;
    o_write_tag_array  = 1'b0;
    o_fsm_busy         = 1'b1;
    o_mem_addr         = i_miss_addr;
    o_cache_addr       = i_miss_addr;
    case (r_state)
      S_IDLE: begin
        o_fsm_busy         = 1'b0;
        o_write_data_array = i_wrt;
        if (w_miss) begin
          o_fsm_busy         = 1'b1;
          o_write_data_array = 1'b0;
          w_latch            = 1'b1;
          w_state_nxt        = (WRITEBACK != 0 && i_victim_dirty) ? S_EVICT : S_FILL;
        end
      end
      S_EVICT: begin
        o_mem_addr   = f_word_addr(r_victim_addr, r_evict_cnt[WB-1:0]);
        o_cache_addr = f_word_addr(r_miss_addr, r_evict_cnt[WB-1:0]);
        if (!i_pause) begin
          o_cache_rd   = 1'b1;
          o_mem_wr_req = 1'b1;
          if (r_evict_cnt == CW'(WORDS-1)) begin
            w_evict_cnt_nxt = '0;
            w_state_nxt     = S_FILL;
          end else begin
            w_evict_cnt_nxt = r_evict_cnt + 1'b1;
          end
        end
      end
      S_FILL: begin
        o_mem_addr   = f_word_addr(r_miss_addr, r_req_cnt[WB-1:0]);
        o_cache_addr = f_word_addr(r_miss_addr, r_ret_cnt[WB-1:0]);
        // Top counter bit set means every word has been requested; hold until exit.
        if (!i_pause && !r_req_cnt[WB]) begin
          o_mem_rd_req  = 1'b1;
          w_req_cnt_nxt = r_req_cnt + 1'b1;
        end
        if (i_mem_data_vld) begin
          o_write_data_array = 1'b1;
          if (r_ret_cnt == CW'(WORDS-1)) begin
            o_write_tag_array = 1'b1;
            w_state_nxt       = S_IDLE;
            w_req_cnt_nxt     = '0;
            w_ret_cnt_nxt     = '0;
          end else begin
            w_ret_cnt_nxt = r_ret_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_evict_cnt   <= '0;
      r_req_cnt     <= '0;
      r_ret_cnt     <= '0;
      r_miss_addr   <= '0;
      r_victim_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_evict_cnt <= w_evict_cnt_nxt;
      r_req_cnt   <= w_req_cnt_nxt;
      r_ret_cnt   <= w_ret_cnt_nxt;
      if (w_latch) begin
        r_miss_addr   <= i_miss_addr;
        r_victim_addr <= i_victim_addr;
      end
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: reset/idle, clean and dirty misses, pause,
// address change, reset mid-fill, and a WORDS=4/16, BYTE_OFF=2, ADDR_W=32 sweep.
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic rst_n, wrt, zero;
  always #5 clk = ~clk;

  // DUT A: 16-bit, 8 words, 2-byte words, write-back enabled
  logic        a_miss, a_dirty, a_pause, a_vld;
  logic [15:0] a_miss_addr, a_victim;
  logic        a_rd, a_wr, a_crd, a_wda, a_tag, a_busy;
  logic [15:0] a_maddr, a_caddr;

  cache_fill_ctrl #(.ADDR_W(16), .WORDS(8), .BYTE_OFF(1), .WRITEBACK(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_miss_detected(a_miss), .i_miss_addr(a_miss_addr),
    .i_victim_dirty(a_dirty), .i_victim_addr(a_victim), .i_wrt(wrt), .i_pause(a_pause),
    .i_mem_data_vld(a_vld), .o_mem_rd_req(a_rd), .o_mem_wr_req(a_wr), .o_mem_addr(a_maddr),
    .o_cache_addr(a_caddr), .o_cache_rd(a_crd), .o_write_data_array(a_wda),
    .o_write_tag_array(a_tag), .o_fsm_busy(a_busy));

  // DUTs B (4 words) and C (16 words): 32-bit, 4-byte words, no write-back
  logic        s_miss;
  logic [31:0] s_miss_addr, s_victim;
  logic        b_vld = 1'b0, c_vld = 1'b0;
  logic        b_rd, b_wr, b_crd, b_wda, b_tag, b_busy;
  logic        c_rd, c_wr, c_crd, c_wda, c_tag, c_busy;
  logic [31:0] b_maddr, b_caddr, c_maddr, c_caddr;

  cache_fill_ctrl #(.ADDR_W(32), .WORDS(4), .BYTE_OFF(2), .WRITEBACK(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_miss_detected(s_miss), .i_miss_addr(s_miss_addr),
    .i_victim_dirty(1'b1), .i_victim_addr(s_victim), .i_wrt(zero), .i_pause(zero),
    .i_mem_data_vld(b_vld), .o_mem_rd_req(b_rd), .o_mem_wr_req(b_wr), .o_mem_addr(b_maddr),
    .o_cache_addr(b_caddr), .o_cache_rd(b_crd), .o_write_data_array(b_wda),
    .o_write_tag_array(b_tag), .o_fsm_busy(b_busy));

  cache_fill_ctrl #(.ADDR_W(32), .WORDS(16), .BYTE_OFF(2), .WRITEBACK(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_miss_detected(s_miss), .i_miss_addr(s_miss_addr),
    .i_victim_dirty(1'b1), .i_victim_addr(s_victim), .i_wrt(zero), .i_pause(zero),
    .i_mem_data_vld(c_vld), .o_mem_rd_req(c_rd), .o_mem_wr_req(c_wr), .o_mem_addr(c_maddr),
    .o_cache_addr(c_caddr), .o_cache_rd(c_crd), .o_write_data_array(c_wda),
    .o_write_tag_array(c_tag), .o_fsm_busy(c_busy));

  // One-cycle memory for the sweep DUTs
  always @(posedge clk) begin
    b_vld <= b_rd;
    c_vld <= c_rd;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Miss on 0x1234 (victim 0xA230), memory latency 4. Starts at posedge+1.
  task automatic a_run(input bit dirty, input int pst, input int plen, input bit chg,
                       input int rst_after, output int tag_cyc, output int busy_n);
    bit req_at[0:127];
    int nreq, nret, t, fs;
    bit done, stop, exp_ev, exp_rd;
    for (int i = 0; i < 128; i++) req_at[i] = 1'b0;
    nreq = 0; nret = 0; t = 0; done = 0; stop = 0;
    tag_cyc = -1; busy_n = 0;
    fs = dirty ? 9 : 1;
    a_miss_addr = 16'h1234; a_victim = 16'hA230; a_dirty = dirty;
    while (t < 80 && !done && !stop) begin
      a_miss  = (t == 0);
      a_pause = (t >= pst && t < pst + plen);
      a_vld   = (t >= 4) && req_at[t-4];
      if (chg && t >= 3) begin
        a_miss_addr = 16'hFFFF;
        a_victim    = 16'h0000;
      end
      #4;
      exp_ev = dirty && t >= 1 && t <= 8;
      exp_rd = t >= fs && nreq < 8 && !a_pause;
      chk("busy", a_busy, 1);
      if (a_busy) busy_n++;
      chk("ev_wr", a_wr, exp_ev);
      chk("ev_crd", a_crd, exp_ev);
      if (exp_ev) begin
        chk("ev_maddr", a_maddr, 16'hA230 + 2 * (t - 1));
        chk("ev_caddr", a_caddr, 16'h1230 + 2 * (t - 1));
      end
      chk("rd_req", a_rd, exp_rd);
      req_at[t] = a_rd;
      if (exp_rd) begin
        chk("rd_addr", a_maddr, 16'h1230 + 2 * nreq);
        nreq++;
      end
      chk("wda", a_wda, a_vld);
      chk("tag", a_tag, a_vld && nret == 7);
      if (a_vld) begin
        chk("wr_caddr", a_caddr, 16'h1230 + 2 * nret);
        nret++;
        if (nret == 8) begin
          done = 1;
          tag_cyc = t;
        end
      end
      if (rst_after != 0 && nret == rst_after) stop = 1;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    if (!done && !stop) chk("timeout", 0, 1);
    if (!stop) begin
      a_miss = 0; a_pause = 0; a_vld = 0; a_miss_addr = 16'h1234;
      #4;
      chk("busy_after", a_busy, 0);
      chk("rd_after", a_rd, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int tc, bn;
    zero = 0; rst_n = 0; wrt = 1;
    a_miss = 1; a_miss_addr = 16'h5556; a_victim = 16'h0; a_dirty = 1; a_pause = 0; a_vld = 0;
    s_miss = 0; s_miss_addr = 32'h0; s_victim = 32'h0;
    #3;
    chk("rst_busy", a_busy, 0);
    chk("rst_wda", a_wda, 1);
    chk("rst_rd", a_rd, 0);
    chk("rst_wr", a_wr, 0);
    chk("rst_crd", a_crd, 0);
    chk("rst_tag", a_tag, 0);
    chk("rst_maddr", a_maddr, 16'h5556);
    chk("rst_caddr", a_caddr, 16'h5556);
    a_miss = 0;
    @(posedge clk); #1;
    rst_n = 1;
    #3;
    chk("idle_wda", a_wda, 1);
    chk("idle_busy", a_busy, 0);
    chk("idle_rd", a_rd, 0);
    wrt = 0; a_vld = 1;
    #1;
    chk("stray_wda", a_wda, 0);
    chk("stray_busy", a_busy, 0);
    @(posedge clk); #1;
    a_vld = 0;

    // clean miss: last req cycle 8, tag at 8+4, busy cycles 0..12
    a_run(0, 0, 0, 0, 0, tc, bn);
    chk("clean_tagcyc", tc, 12);
    chk("clean_busy_n", bn, 13);
    // pause cycles 3..5 after two reads
    a_run(0, 3, 3, 0, 0, tc, bn);
    chk("pause_tagcyc", tc, 15);
    chk("pause_busy_n", bn, 16);
    a_run(0, 0, 0, 1, 0, tc, bn);
    chk("chg_tagcyc", tc, 12);
    // dirty: 8 evict cycles, then fill requests 9..16
    a_run(1, 0, 0, 0, 0, tc, bn);
    chk("dirty_tagcyc", tc, 20);
    chk("dirty_busy_n", bn, 21);

    // reset after the 5th return, with a stray return and a moved miss_addr
    a_run(0, 0, 0, 0, 5, tc, bn);
    rst_n = 0; a_vld = 1; a_miss = 0; a_miss_addr = 16'h4444;
    #1;
    chk("mrst_busy", a_busy, 0);
    chk("mrst_rd", a_rd, 0);
    chk("mrst_tag", a_tag, 0);
    chk("mrst_wda", a_wda, 0);
    chk("mrst_maddr", a_maddr, 16'h4444);
    @(posedge clk); #1;
    rst_n = 1;
    #3;
    chk("post_wda", a_wda, 0);
    chk("post_busy", a_busy, 0);
    @(posedge clk); #1;
    a_vld = 0;
    a_run(0, 0, 0, 0, 0, tc, bn);
    chk("restart_tagcyc", tc, 12);

    // sweep: B base 0x12345670 (OFF_W=4), C base 0x12345640 (OFF_W=6)
    s_miss_addr = 32'h1234_5678; s_victim = 32'hDEAD_BEEF;
    for (int t = 0; t <= 18; t++) begin
      s_miss = (t == 0);
      #4;
      chk("b_busy", b_busy, t <= 5);
      chk("b_wr", b_wr, 0);
      chk("b_rd", b_rd, t >= 1 && t <= 4);
      if (t >= 1 && t <= 4) chk("b_maddr", b_maddr, 32'h1234_5670 + 4 * (t - 1));
      chk("b_wda", b_wda, t >= 2 && t <= 5);
      if (t >= 2 && t <= 5) chk("b_caddr", b_caddr, 32'h1234_5670 + 4 * (t - 2));
      chk("b_tag", b_tag, t == 5);
      chk("c_busy", c_busy, t <= 17);
      chk("c_wr", c_wr, 0);
      chk("c_rd", c_rd, t >= 1 && t <= 16);
      if (t >= 1 && t <= 16) chk("c_maddr", c_maddr, 32'h1234_5640 + 4 * (t - 1));
      chk("c_wda", c_wda, t >= 2 && t <= 17);
      if (t >= 2 && t <= 17) chk("c_caddr", c_caddr, 32'h1234_5640 + 4 * (t - 2));
      chk("c_tag", c_tag, t == 17);
      if (t == 3) s_miss_addr = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
